// File: rtl/nld_pkg.sv
// Shared types and constants for the nld stream shell and its tanh core.
package nld_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic signed [15:0] drive_t;

  localparam int     NLD_CORE_LAT    = 4;
  localparam drive_t NLD_DRIVE_UNITY = 16'sh4000;

  // Symmetric clamp into Q1.15, so -1.0 never appears and negation is always safe
  function automatic sample_t sat_q15(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -32'sd32767) begin
      return 16'sh8001;
    end else begin
      return sample_t'(v[15:0]);
    end
  endfunction

endpackage

// File: rtl/nld_stream_shell_if.sv
// Valid/ready sample stream carrying one Q1.15 word per transfer.
interface nld_stream_shell_if;
  import nld_pkg::*;

  sample_t tdata;
  logic    tvalid;
  logic    tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/nld_stream_fifo.sv
// Synchronous FIFO with registered flags; head word is presented without a read strobe.
module nld_stream_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic             empty_q;
  logic             full_q;
  logic             do_rd_s;

  assign do_rd_s = rd_en_i & ~empty_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({wr_en_i, do_rd_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == (AW+1)'(0));
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Stale storage is masked so the head reads zero whenever nothing is queued
  assign rd_data_o = empty_q ? '0 : mem_q[rd_ptr_q];
  assign empty_o   = empty_q;
  assign full_o    = full_q;

endmodule

// File: rtl/nld_tanh_core_16.sv
// Fixed four-cycle soft-clip core: y = knee(sat(x * drive)), knee halves slope above 0.5.
module nld_tanh_core_16
  import nld_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  sample_t x,
  input  drive_t  drive,
  output sample_t y
);

  sample_t            x1_q;
  drive_t             d1_q;
  logic signed [31:0] p2_q;
  sample_t            v3_q;
  sample_t            y_q;

  logic signed [31:0] sh_s;
  logic [15:0]        mag_s;
  logic [15:0]        knee_s;
  sample_t            knee_y_s;

  always_comb begin
    sh_s  = p2_q >>> 14;
    mag_s = v3_q[15] ? (16'd0 - 16'(v3_q)) : 16'(v3_q);
    if (mag_s > 16'd16384) begin
      knee_s = 16'd16384 + ((mag_s - 16'd16384) >> 1);
    end else begin
      knee_s = mag_s;
    end
    knee_y_s = v3_q[15] ? sample_t'(16'd0 - knee_s) : sample_t'(knee_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1_q <= 16'sh0000;
      d1_q <= 16'sh0000;
      p2_q <= 32'sh0000_0000;
      v3_q <= 16'sh0000;
      y_q  <= 16'sh0000;
    end else if (en) begin
      x1_q <= x;
      d1_q <= drive;
      p2_q <= 32'(x1_q) * 32'(d1_q);
      v3_q <= sat_q15(sh_s);
      y_q  <= knee_y_s;
    end else begin
      y_q  <= y_q;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/nld_stream_shell.sv
// Stream wrapper around nld_tanh_core_16 with credit-limited output FIFO.
// Optional per-sample bypass selected by defining NLD_STREAM_BYPASS_EN.
module nld_stream_shell
  import nld_pkg::*;
#(
  parameter int LAT        = NLD_CORE_LAT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  drive_t              drive_i,
`ifdef NLD_STREAM_BYPASS_EN
  input  logic                bypass_i,
`endif
  nld_stream_shell_if.slave   s_if,
  nld_stream_shell_if.master  m_if
);

  localparam int OW = $clog2(FIFO_DEPTH) + 1;

  drive_t        drive_q;
  sample_t       x_q;
  logic [LAT:0]  vld_q;
  logic [OW-1:0] occ_q;
  logic [OW-1:0] occ_d;

  logic          accept_s;
  logic          pop_s;
  sample_t       y_s;
  sample_t       fifo_wdata_s;
  logic [15:0]   fifo_rdata_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;

  // Credits cover both in-flight and queued samples, so a FIFO write never finds it full
  assign s_if.tready = ~rst & (occ_q < OW'(FIFO_DEPTH)) & ~fifo_full_s;
  assign accept_s    = s_if.tvalid & s_if.tready;
  assign m_if.tvalid = ~fifo_empty_s;
  assign m_if.tdata  = sample_t'(fifo_rdata_s);
  assign pop_s       = m_if.tvalid & m_if.tready;

  always_comb begin
    occ_d = occ_q;
    case ({accept_s, pop_s})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drive_q <= NLD_DRIVE_UNITY;
      x_q     <= 16'sh0000;
      vld_q   <= '0;
      occ_q   <= '0;
    end else begin
      drive_q <= drive_i;
      if (accept_s) x_q <= s_if.tdata;
      vld_q   <= {vld_q[LAT-1:0], accept_s};
      occ_q   <= occ_d;
    end
  end

`ifdef NLD_STREAM_BYPASS_EN
  logic [LAT:0] byp_q;
  sample_t      xd_q [1:LAT];

  // Bypass bit and raw sample ride alongside vld so each sample keeps its own choice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_q <= '0;
      for (int i = 1; i <= LAT; i++) xd_q[i] <= 16'sh0000;
    end else begin
      byp_q   <= {byp_q[LAT-1:0], accept_s & bypass_i};
      xd_q[1] <= x_q;
      for (int i = 2; i <= LAT; i++) xd_q[i] <= xd_q[i-1];
    end
  end

  assign fifo_wdata_s = byp_q[LAT] ? xd_q[LAT] : y_s;
`else
  assign fifo_wdata_s = y_s;
`endif

  nld_tanh_core_16 u_core (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .x     (x_q),
    .drive (drive_q),
    .y     (y_s)
  );

  nld_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (vld_q[LAT]),
    .wr_data_i (16'(fifo_wdata_s)),
    .rd_en_i   (pop_s),
    .rd_data_o (fifo_rdata_s),
    .empty_o   (fifo_empty_s),
    .full_o    (fifo_full_s)
  );

endmodule
